// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Sends start(0), DATA_W data bits LSB first, optional even parity, and stop(1).
// Each bit is held for CLKS_PER_BIT clocks.
// Ports:
//   clk      - clock; all state changes on the rising edge
//   reset    - asynchronous, active-low reset
//   data_in  - word to send; captured on the accept edge
//   valid_in - data_in is valid
//   ready    - idle; the block can accept a word
//   tx       - serial line; idles high
//   busy     - a frame is in progress
//   done     - one-clock pulse when a frame completes
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [CW-1:0]       clkcnt_q, clkcnt_d;
  logic                done_q, done_d;
  logic                bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      clkcnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      clkcnt_q <= clkcnt_d;
      done_q   <= done_d;
    end
  end

  // Last clock of the current serial bit.
  assign bit_end = (clkcnt_q == CLK_LAST);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    clkcnt_d = '0;
    done_d   = 1'b0;
    // Inside a frame, count clocks within the bit; wraps to 0 at each boundary.
    if (state_q != IDLE && !bit_end) clkcnt_d = clkcnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          shreg_d  = data_in;
          par_d    = ^data_in;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is decoded from registered state only, so reset drives it high at once.
  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shreg_q[0];
      PARITY:  tx = par_q;
      default: tx = 1'b1;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = !ready;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx. Three instances share clock and reset:
// u0 defaults, u1 with parity, u2 with CLKS_PER_BIT=4.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din0 = '0, din1 = '0, din2 = '0;
  logic       vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0;
  logic       rdy0, rdy1, rdy2, tx0, tx1, tx2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  serial_frame_tx u0 (.clk(clk), .reset(reset), .data_in(din0), .valid_in(vld0),
                      .ready(rdy0), .tx(tx0), .busy(bsy0), .done(dn0));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .data_in(din1), .valid_in(vld1),
    .ready(rdy1), .tx(tx1), .busy(bsy1), .done(dn1));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u2 (
    .clk(clk), .reset(reset), .data_in(din2), .valid_in(vld2),
    .ready(rdy2), .tx(tx2), .busy(bsy2), .done(dn2));

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vld0 = 1'b1; vld1 = 1'b1; vld2 = 1'b1;
    din0 = 8'hA5; din1 = 8'hA5; din2 = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2} !== 12'b111_111_000_000) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: tx/rdy/busy/done=%b expected 111111000000", i,
                 {tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2});
      end
    end
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    reset = 1'b1;
    tick();
    tests++;
    if ({tx0, tx1, tx2, bsy0, bsy1, bsy2, dn0} !== 7'b111_000_0) begin
      fails++;
      $display("FAIL reset_release: tx/busy/done=%b expected 1110000",
               {tx0, tx1, tx2, bsy0, bsy1, bsy2, dn0});
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] exp = 10'b1101001010; // 8'hA5 frame, index = cycle after accept
    din0 = 8'hA5; vld0 = 1'b1;
    tick();
    vld0 = 1'b0; din0 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx0 !== exp[i] || bsy0 !== 1'b1 || dn0 !== 1'b0) begin
        fails++;
        $display("FAIL single_frame cycle %0d: tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 i, tx0, bsy0, dn0, exp[i]);
      end
      tick();
    end
    tests++;
    if (dn0 !== 1'b1 || rdy0 !== 1'b1 || tx0 !== 1'b1) begin
      fails++;
      $display("FAIL single_frame_end: done=%b ready=%b tx=%b expected 1 1 1", dn0, rdy0, tx0);
    end
    tick();
    tests++;
    if (dn0 !== 1'b0) begin
      fails++;
      $display("FAIL single_done_clear: done=%b expected 0", dn0);
    end
  endtask

  task automatic test_parity();
    logic [10:0] exp [2];
    logic [7:0]  dat [2];
    exp[0] = 11'b11000001110; dat[0] = 8'h07; // parity bit 1
    exp[1] = 11'b10000000110; dat[1] = 8'h03; // parity bit 0
    for (int k = 0; k < 2; k++) begin
      din1 = dat[k]; vld1 = 1'b1;
      tick();
      vld1 = 1'b0;
      for (int i = 0; i < 11; i++) begin
        tests++;
        if (tx1 !== exp[k][i]) begin
          fails++;
          $display("FAIL parity_frame data=%h cycle %0d: tx=%b expected %b", dat[k], i, tx1, exp[k][i]);
        end
        tick();
      end
      tests++;
      if (dn1 !== 1'b1 || rdy1 !== 1'b1) begin
        fails++;
        $display("FAIL parity_end data=%h: done=%b ready=%b expected 1 1", dat[k], dn1, rdy1);
      end
      tick();
    end
  endtask

  task automatic test_stretch();
    logic e;
    din2 = 8'h81; vld2 = 1'b1;
    tick();
    vld2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      e = (i < 4) ? 1'b0 : (i < 8) ? 1'b1 : (i < 32) ? 1'b0 : 1'b1;
      tests++;
      if (tx2 !== e || bsy2 !== 1'b1 || dn2 !== 1'b0) begin
        fails++;
        $display("FAIL stretch cycle %0d: tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 i, tx2, bsy2, dn2, e);
      end
      tick();
    end
    tests++;
    if (dn2 !== 1'b1 || rdy2 !== 1'b1 || tx2 !== 1'b1) begin
      fails++;
      $display("FAIL stretch_end: done=%b ready=%b tx=%b expected 1 1 1", dn2, rdy2, tx2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1 = {1'b1, 8'h3C, 1'b0};
    logic [9:0] f2 = {1'b1, 8'hC3, 1'b0};
    din0 = 8'h3C; vld0 = 1'b1;
    tick();
    din0 = 8'hC3; // still valid: next word waits for the idle cycle
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx0 !== f1[i] || bsy0 !== 1'b1) begin
        fails++;
        $display("FAIL b2b_first cycle %0d: tx=%b busy=%b expected tx=%b busy=1", i, tx0, bsy0, f1[i]);
      end
      tick();
    end
    tests++;
    if (rdy0 !== 1'b1 || dn0 !== 1'b1 || tx0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle: ready=%b done=%b tx=%b expected 1 1 1", rdy0, dn0, tx0);
    end
    tick();
    vld0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx0 !== f2[i] || bsy0 !== 1'b1 || dn0 !== 1'b0) begin
        fails++;
        $display("FAIL b2b_second cycle %0d: tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 i, tx0, bsy0, dn0, f2[i]);
      end
      tick();
    end
    tests++;
    if (dn0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_done: done=%b expected 1", dn0);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    logic [9:0] f = {1'b1, 8'h96, 1'b0};
    din0 = 8'h96; vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin din0 = 8'hFF; vld0 = 1'b1; end
      if (i == 4) vld0 = 1'b0;
      tests++;
      if (tx0 !== f[i] || bsy0 !== 1'b1) begin
        fails++;
        $display("FAIL ignore_busy cycle %0d: tx=%b busy=%b expected tx=%b busy=1", i, tx0, bsy0, f[i]);
      end
      tick();
    end
    tests++;
    if (dn0 !== 1'b1 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL ignore_busy_end: done=%b ready=%b expected 1 1", dn0, rdy0);
    end
    tick();
    tests++;
    if (bsy0 !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy_no_restart: busy=%b expected 0", bsy0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f = {1'b1, 8'h5A, 1'b0};
    logic       saw_done;
    din0 = 8'h00; vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    repeat (4) tick(); // now in DATA bit 3, tx low
    tests++;
    if (tx0 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_pre: tx=%b expected 0", tx0);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (tx0 !== 1'b1 || rdy0 !== 1'b1 || bsy0 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async: tx=%b ready=%b busy=%b expected 1 1 0", tx0, rdy0, bsy0);
    end
    tick();
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dn0 !== 1'b0 || rdy0 !== 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_no_done: stray done/busy seen=%b expected 0", saw_done);
    end
    din0 = 8'h5A; vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx0 !== f[i]) begin
        fails++;
        $display("FAIL mid_reset_newframe cycle %0d: tx=%b expected %b", i, tx0, f[i]);
      end
      tick();
    end
    tests++;
    if (dn0 !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_newframe_done: done=%b expected 1", dn0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_stretch();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
